// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light sequencer: phase codes, lamp patterns and
// the lamp decode used by both the sequencer and the board display logic.
package tlc_pkg;

   typedef enum logic [2:0] {
      ST_ALLRED_A  = 3'd0,
      ST_NS_GREEN  = 3'd1,
      ST_NS_YELLOW = 3'd2,
      ST_ALLRED_B  = 3'd3,
      ST_EW_GREEN  = 3'd4,
      ST_EW_YELLOW = 3'd5,
      ST_PED_WALK  = 3'd6,
      ST_FLASH     = 3'd7
   } state_e;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef struct packed {
      logic [2:0] ns;
      logic [2:0] ew;
   } lamps_t;

   // Any direction not explicitly lit green/yellow shows red; FLASH blinks both yellows.
   function automatic lamps_t lamp_decode(input state_e st, input logic flash_on);
      lamps_t l;
      l.ns = LAMP_R;
      l.ew = LAMP_R;
      case (st)
         ST_NS_GREEN:  l.ns = LAMP_G;
         ST_NS_YELLOW: l.ns = LAMP_Y;
         ST_EW_GREEN:  l.ew = LAMP_G;
         ST_EW_YELLOW: l.ew = LAMP_Y;
         ST_FLASH: begin
            l.ns = flash_on ? LAMP_Y : LAMP_OFF;
            l.ew = l.ns;
         end
         default: ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Board-side signals of the traffic-light sequencer: raw inputs in, lamps/countdown out.
interface traffic_light_sequencer_if #(
   parameter int CNT_W = 5
);
   logic             oneHz;
   logic             ped_req;
   logic             night_mode;
   logic [2:0]       ns_light;
   logic [2:0]       ew_light;
   logic             walk;
   logic [CNT_W-1:0] sec_left;
   logic [2:0]       phase;

   modport master (
      output oneHz, ped_req, night_mode,
      input  ns_light, ew_light, walk, sec_left, phase
   );

   modport slave (
      input  oneHz, ped_req, night_mode,
      output ns_light, ew_light, walk, sec_left, phase
   );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, plus a registered one-clock pulse
// on each rising edge of the synchronised level.
module sync_edge_det (
   input  logic Clock,
   input  logic reset,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);
   logic meta_q, sync_q, prev_q, rise_q;

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = rise_q;
endmodule

// File: rtl/traffic_light_sequencer.sv
// Two-way traffic-light phase controller stepped by a 1 Hz tick, with a pedestrian
// walk phase inserted at all-red clearance and a flashing-yellow night mode.
module traffic_light_sequencer
   import tlc_pkg::*;
#(
   parameter int GREEN_S  = 10,
   parameter int YELLOW_S = 3,
   parameter int ALLRED_S = 1,
   parameter int WALK_S   = 8,
   parameter int CNT_W    = 5
) (
   input logic                      Clock,
   input logic                      reset,
   traffic_light_sequencer_if.slave tlc_if
);
   localparam logic [CNT_W-1:0] GREEN_T  = CNT_W'(GREEN_S - 1);
   localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(YELLOW_S - 1);
   localparam logic [CNT_W-1:0] ALLRED_T = CNT_W'(ALLRED_S - 1);
   localparam logic [CNT_W-1:0] WALK_T   = CNT_W'(WALK_S - 1);

   if (GREEN_S < 1 || GREEN_S > 2**CNT_W || YELLOW_S < 1 || YELLOW_S > 2**CNT_W ||
       ALLRED_S < 1 || ALLRED_S > 2**CNT_W || WALK_S < 1 || WALK_S > 2**CNT_W) begin : g_bad_duration
      $error("traffic_light_sequencer: phase duration outside 1..2**CNT_W");
   end

   logic tick, ped_rise, night_lvl;
   logic one_hz_lvl_unused, ped_lvl_unused, night_rise_unused;

   sync_edge_det u_sync_one_hz (.Clock, .reset, .d_i(tlc_if.oneHz),
                                .level_o(one_hz_lvl_unused), .rise_o(tick));
   sync_edge_det u_sync_ped    (.Clock, .reset, .d_i(tlc_if.ped_req),
                                .level_o(ped_lvl_unused), .rise_o(ped_rise));
   sync_edge_det u_sync_night  (.Clock, .reset, .d_i(tlc_if.night_mode),
                                .level_o(night_lvl), .rise_o(night_rise_unused));

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             ped_pending_q, ped_pending_d;
   dir_e             next_dir_q, next_dir_d;
   logic             flash_on_q, flash_on_d;
   lamps_t           lamps_q, lamps_d;
   logic             walk_q, walk_d;
   logic [CNT_W-1:0] sec_left_q, sec_left_d;

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_ALLRED_A;
         timer_q       <= ALLRED_T;
         ped_pending_q <= 1'b0;
         next_dir_q    <= DIR_NS;
         flash_on_q    <= 1'b0;
         lamps_q       <= '{ns: LAMP_R, ew: LAMP_R};
         walk_q        <= 1'b0;
         sec_left_q    <= ALLRED_T;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         ped_pending_q <= ped_pending_d;
         next_dir_q    <= next_dir_d;
         flash_on_q    <= flash_on_d;
         lamps_q       <= lamps_d;
         walk_q        <= walk_d;
         sec_left_q    <= sec_left_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path through the block infers a latch.
      state_d       = state_q;
      timer_d       = timer_q;
      next_dir_d    = next_dir_q;
      flash_on_d    = flash_on_q;
      ped_pending_d = ped_pending_q | ped_rise;
      if (tick) begin
         if (state_q == ST_FLASH) begin
            if (night_lvl) begin
               flash_on_d = ~flash_on_q;
            end else begin
               state_d = ST_ALLRED_A;
               timer_d = ALLRED_T;
            end
         end else if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
         end else begin
            case (state_q)
               ST_ALLRED_A, ST_ALLRED_B: begin
                  // Night mode outranks a waiting pedestrian; the request survives FLASH.
                  if (night_lvl) begin
                     state_d    = ST_FLASH;
                     timer_d    = '0;
                     flash_on_d = 1'b1;
                  end else if (ped_pending_q) begin
                     state_d = ST_PED_WALK;
                     timer_d = WALK_T;
                     if (state_q == ST_ALLRED_A) next_dir_d = DIR_NS;
                     else                        next_dir_d = DIR_EW;
                  end else if (state_q == ST_ALLRED_A) begin
                     state_d = ST_NS_GREEN;
                     timer_d = GREEN_T;
                  end else begin
                     state_d = ST_EW_GREEN;
                     timer_d = GREEN_T;
                  end
               end
               ST_NS_GREEN:  begin state_d = ST_NS_YELLOW; timer_d = YELLOW_T; end
               ST_NS_YELLOW: begin state_d = ST_ALLRED_B;  timer_d = ALLRED_T; end
               ST_EW_GREEN:  begin state_d = ST_EW_YELLOW; timer_d = YELLOW_T; end
               ST_EW_YELLOW: begin state_d = ST_ALLRED_A;  timer_d = ALLRED_T; end
               ST_PED_WALK: begin
                  state_d = (next_dir_q == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;
                  timer_d = GREEN_T;
               end
               default: ;
            endcase
         end
      end
      // A press landing in the same cycle as walk entry is absorbed by that walk.
      if (state_d == ST_PED_WALK && state_q != ST_PED_WALK) ped_pending_d = 1'b0;
   end

   always_comb begin
      lamps_d    = lamp_decode(state_d, flash_on_d);
      walk_d     = (state_d == ST_PED_WALK);
      sec_left_d = (state_d == ST_FLASH) ? '0 : timer_d;
   end

   assign tlc_if.ns_light = lamps_q.ns;
   assign tlc_if.ew_light = lamps_q.ew;
   assign tlc_if.walk     = walk_q;
   assign tlc_if.sec_left = sec_left_q;
   assign tlc_if.phase    = state_q;
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer: random-timed requests checked every cycle against
// a phase-schedule model, plus literal expectations for the reference sequences.
module tb_traffic_light_sequencer;
   localparam int GREEN_S = 4, YELLOW_S = 2, ALLRED_S = 1, WALK_S = 3, CNT_W = 5;
   localparam int P_ALLRED_A = 0, P_NS_GREEN = 1, P_NS_YELLOW = 2, P_ALLRED_B = 3;
   localparam int P_EW_GREEN = 4, P_EW_YELLOW = 5, P_WALK = 6, P_FLASH = 7;

   // {phase, sec_left} after each change for one undisturbed cycle from reset.
   localparam logic [7:0] EXP_TRACE [15] = '{8'h00, 8'h23, 8'h22, 8'h21, 8'h20, 8'h41, 8'h40,
                                             8'h60, 8'h83, 8'h82, 8'h81, 8'h80, 8'hA1, 8'hA0, 8'h00};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   traffic_light_sequencer_if #(.CNT_W(CNT_W)) tlc_if ();

   traffic_light_sequencer #(
      .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .ALLRED_S(ALLRED_S), .WALK_S(WALK_S), .CNT_W(CNT_W)
   ) dut (
      .Clock(clk),
      .reset(rst_n),
      .tlc_if(tlc_if)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 0;
   bit trace_en = 0;
   bit hz_en = 0;
   int walk_rises = 0;
   logic walk_prev = 1'b0;
   logic [7:0] trace[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      int ph;
      int left;
      bit pend;
      bit dir_ew;
      bit flash_on;
   } model_t;

   model_t m;
   logic [4:1] hz_h, ped_h, night_h;

   function automatic int dur_of(input int ph);
      case (ph)
         P_NS_GREEN, P_EW_GREEN:   return GREEN_S;
         P_NS_YELLOW, P_EW_YELLOW: return YELLOW_S;
         P_WALK:                   return WALK_S;
         P_FLASH:                  return 1;
         default:                  return ALLRED_S;
      endcase
   endfunction

   function automatic model_t enter(input model_t s, input int ph);
      model_t n = s;
      n.ph   = ph;
      n.left = dur_of(ph) - 1;
      if (ph == P_FLASH) n.flash_on = 1'b1;
      return n;
   endfunction

   // One clock of the schedule: the six-phase ring with walk and flash detours.
   function automatic model_t model_step(input model_t s, input bit tick, input bit night,
                                         input bit ped_rise);
      model_t n = s;
      if (tick) begin
         if (s.ph == P_FLASH) begin
            if (night) n.flash_on = !s.flash_on;
            else       n = enter(n, P_ALLRED_A);
         end else if (s.left > 0) begin
            n.left = s.left - 1;
         end else if (s.ph == P_ALLRED_A || s.ph == P_ALLRED_B) begin
            if (night) n = enter(n, P_FLASH);
            else if (s.pend) begin
               n = enter(n, P_WALK);
               n.dir_ew = (s.ph == P_ALLRED_B);
            end else n = enter(n, (s.ph == P_ALLRED_A) ? P_NS_GREEN : P_EW_GREEN);
         end else if (s.ph == P_WALK) begin
            n = enter(n, s.dir_ew ? P_EW_GREEN : P_NS_GREEN);
         end else begin
            n = enter(n, (s.ph + 1) % 6);
         end
      end
      n.pend = (s.pend | ped_rise) & !(n.ph == P_WALK && s.ph != P_WALK);
      return n;
   endfunction

   function automatic logic [2:0] lamp_exp(input model_t s, input bit is_ew);
      int g = is_ew ? P_EW_GREEN : P_NS_GREEN;
      if (s.ph == P_FLASH) return s.flash_on ? 3'b010 : 3'b000;
      if (s.ph == g)       return 3'b001;
      if (s.ph == g + 1)   return 3'b010;
      return 3'b100;
   endfunction

   // Inputs reach the phase logic three clocks after they are sampled; night level two.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m       <= '{ph: P_ALLRED_A, left: ALLRED_S - 1, pend: 1'b0, dir_ew: 1'b0, flash_on: 1'b0};
         hz_h    <= '0;
         ped_h   <= '0;
         night_h <= '0;
      end else begin
         m       <= model_step(m, hz_h[3] & ~hz_h[4], night_h[2], ped_h[3] & ~ped_h[4]);
         hz_h    <= {hz_h[3:1], tlc_if.oneHz};
         ped_h   <= {ped_h[3:1], tlc_if.ped_req};
         night_h <= {night_h[3:1], tlc_if.night_mode};
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ns_light", tlc_if.ns_light, lamp_exp(m, 1'b0));
         check("ew_light", tlc_if.ew_light, lamp_exp(m, 1'b1));
         check("walk", tlc_if.walk, m.ph == P_WALK);
         check("sec_left", tlc_if.sec_left, (m.ph == P_FLASH) ? 0 : m.left);
         check("phase", tlc_if.phase, m.ph);
         check("lamp_conflict", (tlc_if.phase != 3'd7) && (|tlc_if.ns_light[1:0]) &&
                                (|tlc_if.ew_light[1:0]), 1'b0);
         check("walk_not_all_red", tlc_if.walk && !(tlc_if.ns_light == 3'b100 &&
                                   tlc_if.ew_light == 3'b100), 1'b0);
      end
   end

   always @(negedge clk) begin
      walk_prev <= tlc_if.walk;
      if (tlc_if.walk && !walk_prev) walk_rises <= walk_rises + 1;
      if (trace_en && (trace.size() == 0 || {tlc_if.phase, tlc_if.sec_left} != trace[$]))
         trace.push_back({tlc_if.phase, tlc_if.sec_left});
   end

   initial begin
      tlc_if.oneHz = 1'b0;
      wait (hz_en);
      forever begin
         repeat (10) @(posedge clk);
         #2 tlc_if.oneHz = ~tlc_if.oneHz;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_phase(input int p, input int budget);
      bit found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (int'(tlc_if.phase) == p) found = 1;
      end
      check($sformatf("reach_phase_%0d", p), found, 1'b1);
   endtask

   task automatic pulse_ped(input int width);
      @(posedge clk);
      #2 tlc_if.ped_req = 1'b1;
      repeat (width) @(posedge clk);
      #2 tlc_if.ped_req = 1'b0;
   endtask

   initial begin
      int walk0;
      tlc_if.ped_req    = 1'b0;
      tlc_if.night_mode = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rst_ns", tlc_if.ns_light, 3'b100);
      check("rst_ew", tlc_if.ew_light, 3'b100);
      check("rst_walk", tlc_if.walk, 1'b0);
      check("rst_sec_left", tlc_if.sec_left, 0);
      check("rst_phase", tlc_if.phase, 0);
      cmp_en   = 1;
      trace_en = 1;
      hz_en    = 1;

      // Undisturbed cycle: phase lengths and countdown.
      repeat (16 * 20) @(posedge clk);
      trace_en = 0;
      check("trace_len", trace.size() >= 15, 1'b1);
      for (int i = 0; i < 15; i++)
         if (i < trace.size()) check($sformatf("trace_%0d", i), trace[i], EXP_TRACE[i]);

      // Three presses in one green, then a press landing on walk entry: one walk only.
      wait_phase(P_EW_GREEN, 800);
      wait_phase(P_NS_GREEN, 800);
      walk0 = walk_rises;
      for (int i = 0; i < 3; i++) begin
         pulse_ped($urandom_range(3, 6));
         repeat ($urandom_range(3, 12)) @(posedge clk);
      end
      wait_phase(P_ALLRED_B, 800);
      @(posedge tlc_if.oneHz);
      tlc_if.ped_req = 1'b1;
      repeat (4) @(posedge clk);
      #2 tlc_if.ped_req = 1'b0;
      wait_phase(P_WALK, 100);
      check("walk_lamp", tlc_if.walk, 1'b1);
      check("walk_ns_red", tlc_if.ns_light, 3'b100);
      check("walk_ew_red", tlc_if.ew_light, 3'b100);
      wait_phase(P_EW_GREEN, 200);
      wait_phase(P_NS_GREEN, 800);
      wait_phase(P_EW_GREEN, 800);
      wait_phase(P_NS_GREEN, 800);
      check("walk_count_presses", walk_rises - walk0, 1);

      // Night mode raised mid EW green.
      wait_phase(P_EW_GREEN, 800);
      repeat ($urandom_range(5, 60)) @(posedge clk);
      #2 tlc_if.night_mode = 1'b1;
      wait_phase(P_FLASH, 800);
      check("flash_entry_ns", tlc_if.ns_light, 3'b010);
      check("flash_entry_ew", tlc_if.ew_light, 3'b010);
      repeat (25) @(negedge clk);
      check("flash_off_ns", tlc_if.ns_light, 3'b000);
      check("flash_off_ew", tlc_if.ew_light, 3'b000);
      repeat ($urandom_range(40, 100)) @(posedge clk);
      #2 tlc_if.night_mode = 1'b0;
      wait_phase(P_ALLRED_A, 200);
      wait_phase(P_NS_GREEN, 200);

      // Asynchronous reset mid NS yellow discards a pending request.
      wait_phase(P_NS_YELLOW, 800);
      pulse_ped(4);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_ns", tlc_if.ns_light, 3'b100);
      check("midrst_ew", tlc_if.ew_light, 3'b100);
      check("midrst_walk", tlc_if.walk, 1'b0);
      check("midrst_phase", tlc_if.phase, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      walk0 = walk_rises;
      wait_phase(P_EW_GREEN, 800);
      wait_phase(P_NS_GREEN, 800);
      check("walk_count_after_reset", walk_rises - walk0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
